// File: rtl/bar_meter_drv.sv
// bar_meter_drv: multi-channel LED bar-graph driver for chained serial-in /
// parallel-out shift registers (74HC595 style). Each frame snapshots the
// channel levels, converts them to bar patterns (optionally with a decaying
// peak dot), shifts CH*LEDS bits out MSB-first and pulses the latch clock.
module bar_meter_drv #(
    parameter int CH       = 2,
    parameter int DW       = 10,
    parameter int LEDS     = 8,
    parameter int CLKDIV   = 4,
    parameter int HOLD_CYC = 25
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [CH*DW-1:0] i_level,
    input  logic             i_mode,
    input  logic             i_start,
    output logic             o_ser,
    output logic             o_srclk,
    output logic             o_rclk,
    output logic             o_busy
);

    // Frame sequencer states
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] LOAD     = 3'd1;
    localparam logic [2:0] SHIFT_LO = 3'd2;
    localparam logic [2:0] SHIFT_HI = 3'd3;
    localparam logic [2:0] LATCH    = 3'd4;

    localparam int NBITS = CH * LEDS;
    // LED count 0..LEDS per channel
    localparam int NW    = $clog2(LEDS + 1);
    localparam int HW    = (HOLD_CYC < 1) ? 1 : $clog2(HOLD_CYC + 1);
    localparam int DIVW  = (CLKDIV < 2) ? 1 : $clog2(CLKDIV);
    localparam int BCW   = (NBITS < 2) ? 1 : $clog2(NBITS);
    // level*(LEDS+1) < 2^DW * 17 < 2^(DW+5): never overflows
    localparam int PW    = DW + 5;

    localparam logic [HW-1:0]   HOLD_INIT = HW'(HOLD_CYC);
    localparam logic [DIVW-1:0] DIV_LAST  = DIVW'(CLKDIV - 1);
    localparam logic [BCW-1:0]  BIT_LAST  = BCW'(NBITS - 1);

    // Scale a level to a lit-LED count: floor(level*(LEDS+1)/2^DW)
    function automatic logic [NW-1:0] level_to_n(input logic [DW-1:0] lvl);
        logic [PW-1:0] prod;
        prod = PW'(lvl) * PW'(LEDS + 1);
        return NW'(prod >> DW);
    endfunction

    // Bar of n LEDs from bit 0 upward, plus an optional dot at LED pk-1
    function automatic logic [LEDS-1:0] build_pattern(
        input logic [NW-1:0] n,
        input logic [NW-1:0] pk,
        input logic          dot
    );
        logic [LEDS-1:0] pat;
        pat = '0;
        for (int i = 0; i < LEDS; i++) begin
            pat[i] = (i < int'(n)) || (dot && (i == int'(pk) - 1));
        end
        return pat;
    endfunction

    logic [2:0]       state;
    logic [DIVW-1:0]  div_cnt;
    logic [BCW-1:0]   bit_cnt;
    logic             div_last;
    logic             bit_last;

    // Frame snapshot (stage 0) and serial shift word (stage 1)
    logic [CH*DW-1:0] snap_level_p0;
    logic             snap_mode_p0;
    logic [NBITS-1:0] shreg_p1;

    // Peak-hold state per channel
    logic [NW-1:0]    pk      [CH];
    logic [HW-1:0]    hold    [CH];
    logic [NW-1:0]    n_lvl   [CH];
    logic [NW-1:0]    pk_nx   [CH];
    logic [HW-1:0]    hold_nx [CH];
    logic [NBITS-1:0] load_word;

    assign div_last = (div_cnt == DIV_LAST);
    assign bit_last = (bit_cnt == BIT_LAST);

    // Per-channel LED count, peak/hold update and display pattern for LOAD
    always_comb begin
        load_word = '0;
        for (int c = 0; c < CH; c++) begin
            n_lvl[c]   = level_to_n(snap_level_p0[c*DW +: DW]);
            pk_nx[c]   = pk[c];
            hold_nx[c] = hold[c];
            if (n_lvl[c] >= pk[c]) begin
                pk_nx[c]   = n_lvl[c];
                hold_nx[c] = HOLD_INIT;
            end else if (hold[c] != '0) begin
                hold_nx[c] = hold[c] - 1'b1;
            end else if (pk[c] != '0) begin
                pk_nx[c] = pk[c] - 1'b1;
            end
            load_word[c*LEDS +: LEDS] = build_pattern(n_lvl[c], pk_nx[c], snap_mode_p0);
        end
    end

    // Frame sequencer: phase divider and bit counter
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    div_cnt <= '0;
                    bit_cnt <= '0;
                    if (i_start) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    div_cnt <= '0;
                    bit_cnt <= '0;
                    state   <= SHIFT_LO;
                end
                SHIFT_LO: begin
                    if (div_last) begin
                        div_cnt <= '0;
                        state   <= SHIFT_HI;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                SHIFT_HI: begin
                    if (div_last) begin
                        div_cnt <= '0;
                        if (bit_last) begin
                            state <= LATCH;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            state   <= SHIFT_LO;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                LATCH: begin
                    if (div_last) begin
                        div_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: begin
                    div_cnt <= '0;
                    bit_cnt <= '0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    // Peak and hold registers advance once per frame, in LOAD
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int c = 0; c < CH; c++) begin
                pk[c]   <= '0;
                hold[c] <= '0;
            end
        end else if (state == LOAD) begin
            for (int c = 0; c < CH; c++) begin
                pk[c]   <= pk_nx[c];
                hold[c] <= hold_nx[c];
            end
        end
    end

    // Snapshot inputs on an accepted start; load and shift the serial word
    always_ff @(posedge i_clk) begin
        if (state == IDLE && i_start) begin
            snap_level_p0 <= i_level;
            snap_mode_p0  <= i_mode;
        end
        if (state == LOAD) begin
            shreg_p1 <= load_word;
        end else if (state == SHIFT_HI && div_last && !bit_last) begin
            shreg_p1 <= {shreg_p1[NBITS-2:0], 1'b0};
        end
    end

    assign o_busy  = (state != IDLE);
    assign o_srclk = (state == SHIFT_HI);
    assign o_rclk  = (state == LATCH);
    assign o_ser   = ((state == SHIFT_LO) || (state == SHIFT_HI)) && shreg_p1[NBITS-1];

endmodule

// File: doc/bar_meter_drv.md
BAR_METER_DRV -- requirements
Module: bar_meter_drv

Interface
REQ-001 The block SHALL have parameter CH, default 2, giving the number of meter channels (legal range 1..4).
REQ-002 The block SHALL have parameter DW, default 10, giving the unsigned audio level width.
REQ-003 The block SHALL have parameter LEDS, default 8, giving the number of LEDs per channel (legal range 2..16).
REQ-004 The block SHALL have parameter CLKDIV, default 4, giving the i_clk cycles per serial-clock phase (minimum 1).
REQ-005 The block SHALL have parameter HOLD_CYC, default 25, giving the number of frames a peak is held before it decays.
REQ-006 The block SHALL have port i_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 The block SHALL have port i_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 The block SHALL have port i_level, input, CH*DW bits: channel c occupies bits [c*DW +: DW].
REQ-009 The block SHALL have port i_mode, input, 1 bit: 0 selects bar display, 1 selects bar plus peak dot.
REQ-010 The block SHALL have port i_start, input, 1 bit: a frame request, sampled in IDLE only.
REQ-011 The block SHALL have port o_ser, output, 1 bit: shift-register serial data.
REQ-012 The block SHALL have port o_srclk, output, 1 bit: shift clock; data is captured externally on its rising edge.
REQ-013 The block SHALL have port o_rclk, output, 1 bit: latch clock; data is latched externally on its rising edge.
REQ-014 The block SHALL have port o_busy, output, 1 bit: high while a frame is in progress.

Function
REQ-015 The FSM SHALL have the states IDLE, LOAD, SHIFT_LO, SHIFT_HI and LATCH.
REQ-016 In IDLE with i_start=1, the block SHALL capture i_level and i_mode into a snapshot and move to LOAD on the next cycle.
REQ-017 i_start SHALL be ignored in every state other than IDLE.
REQ-018 In LOAD (1 cycle), the block SHALL compute per channel n = floor(level*(LEDS+1)/2^DW), giving a range 0..LEDS, using full-width intermediate arithmetic with no overflow.
REQ-019 Peak update in LOAD SHALL apply these rules per channel, in every mode: if n >= pk then pk<=n and hold<=HOLD_CYC; else if hold>0 then hold<=hold-1; else if pk>0 then pk<=pk-1.
REQ-020 Pattern bits [n-1:0] SHALL be 1 and all other bits 0.
REQ-021 If the snapshot mode is 1 and the updated pk>0, pattern bit pk-1 SHALL also be set.
REQ-022 Shift order SHALL be channel CH-1 down to channel 0, and within each channel bit LEDS-1 down to bit 0, for CH*LEDS bits in total.
REQ-023 For each bit, the block SHALL spend CLKDIV cycles in SHIFT_LO, with o_srclk=0 and o_ser holding the bit value, then CLKDIV cycles in SHIFT_HI, with o_srclk=1 and o_ser stable.
REQ-024 After the last SHIFT_HI, the block SHALL spend CLKDIV cycles in LATCH with o_rclk=1 and o_ser=0, then return to IDLE.
REQ-025 o_busy SHALL be 1 in LOAD, SHIFT_LO, SHIFT_HI and LATCH, and 0 in IDLE.
REQ-026 o_busy SHALL stay high for exactly 1 + 2*CLKDIV*CH*LEDS + CLKDIV cycles per frame.
REQ-027 When i_start is held high continuously, consecutive frames SHALL be separated by exactly one IDLE cycle.
REQ-028 In IDLE, o_srclk, o_rclk and o_ser SHALL all be 0.
REQ-029 Exactly one o_rclk pulse SHALL occur per completed frame.
REQ-030 Changes on i_level or i_mode during a frame SHALL have no effect until the next accepted i_start.

Reset
REQ-031 While i_rst_n=0, the outputs SHALL be o_ser=0, o_srclk=0, o_rclk=0 and o_busy=0, with the FSM in IDLE and every pk and hold at 0.
REQ-032 Reset asserted mid-frame SHALL abort the frame immediately, with no o_rclk pulse for that frame.
REQ-033 The first frame after reset release SHALL behave as a fresh frame, with peaks starting from 0.

Verification (CH=2, DW=10, LEDS=8, CLKDIV=2, HOLD_CYC=3)
REQ-034 Bench: ch0=1023, ch1=0, mode 0, one i_start pulse -> serial stream is 8 zeros then 8 ones; one 2-cycle o_rclk pulse; o_busy high for 67 cycles.
REQ-035 Bench: ch0=512, ch1=1023, mode 0 -> ch0 pattern 0x0F (n=4), ch1 pattern 0xFF; first bit out is 1.
REQ-036 Bench: mode 1, frame 1 with ch0=1023, frames 2..6 with ch0=0 -> ch0 patterns 0xFF, 0x80, 0x80, 0x80, 0x40, 0x20.
REQ-037 Bench: i_start pulsed mid-frame, then i_start held high for 3 frames -> the mid-frame pulse is ignored; frames are 67 busy cycles each with a 1-cycle IDLE gap; exactly 3 o_rclk pulses.
REQ-038 Bench: i_rst_n pulsed low during SHIFT_HI of bit 5 -> all outputs are 0 at once; no o_rclk pulse; the next frame matches REQ-034 exactly.
